// File: rtl/fft4_input_reorder_if.sv
// Sample stream in, parallel 4-word frame out, for the FFT4 loader.
// slave = loader side, master = producer/consumer side.
interface fft4_input_reorder_if #(
  parameter int WIDTH = 32
) ();
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             s_last;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_x0;
  logic [WIDTH-1:0] m_x1;
  logic [WIDTH-1:0] m_x2;
  logic [WIDTH-1:0] m_x3;
  logic             frame_err;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid,
    output m_x0, m_x1, m_x2, m_x3,
    output frame_err
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid,
    input  m_x0, m_x1, m_x2, m_x3,
    input  frame_err
  );
endinterface

// File: rtl/fft4_input_reorder.sv
// FFT4 input loader: prescale, bit-reverse store, ping-pong frames.
// Ports: clk, rst_n (sync, active-low), io (stream in / frame out).
module fft4_input_reorder #(
  parameter int WIDTH    = 32,
  parameter int PRESCALE = 1
) (
  input logic            clk,
  input logic            rst_n,
  fft4_input_reorder_if.slave io
);

  localparam int HALF = WIDTH / 2;
  localparam logic [HALF:0] RND =
    ((HALF+1)'(1) << PRESCALE) >> 1;

  logic [WIDTH-1:0] mem [2][4];
  logic [1:0]       full;
  logic             wr_bank;
  logic             rd_bank;
  logic [1:0]       idx;
  logic             err_q;

  logic [1:0]       full_d;
  logic             wr_d;
  logic             rd_d;
  logic [1:0]       idx_d;
  logic             acc;
  logic             rd;
  logic             fin;
  logic             bad;
  logic [1:0]       waddr;
  logic [WIDTH-1:0] sc;

  // round half up, then arithmetic shift; one guard bit
  // keeps the rounding add from wrapping
  function automatic logic [HALF-1:0] scale(
    input logic [HALF-1:0] c
  );
    logic signed [HALF:0] e;
    e = {c[HALF-1], c} + RND;
    e = e >>> PRESCALE;
    return e[HALF-1:0];
  endfunction

  assign waddr = {idx[0], idx[1]};
  assign sc = {scale(io.s_data[WIDTH-1:HALF]),
               scale(io.s_data[HALF-1:0])};

  assign io.s_ready   = !full[wr_bank];
  assign io.m_valid   = full[rd_bank];
  assign io.m_x0      = mem[rd_bank][0];
  assign io.m_x1      = mem[rd_bank][1];
  assign io.m_x2      = mem[rd_bank][2];
  assign io.m_x3      = mem[rd_bank][3];
  assign io.frame_err = err_q;

  always_comb begin
    acc    = io.s_valid && !full[wr_bank];
    rd     = full[rd_bank] && io.m_ready;
    fin    = acc && (idx == 2'd3) && io.s_last;
    bad    = acc && ((idx == 2'd3) ^ io.s_last);
    full_d = full;
    wr_d   = wr_bank;
    rd_d   = rd_bank;
    idx_d  = idx;
    // read and final write never hit the same bank
    if (rd) begin
      full_d[rd_bank] = 1'b0;
      rd_d            = ~rd_bank;
    end
    if (acc) begin
      unique case (1'b1)
        fin: begin
          full_d[wr_bank] = 1'b1;
          wr_d            = ~wr_bank;
          idx_d           = 2'd0;
        end
        bad:     idx_d = 2'd0;
        default: idx_d = idx + 2'd1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      idx     <= '0;
      err_q   <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < 4; k++) begin
          mem[b][k] <= '0;
        end
      end
    end else begin
      full    <= full_d;
      wr_bank <= wr_d;
      rd_bank <= rd_d;
      idx     <= idx_d;
      err_q   <= bad;
      if (acc) begin
        mem[wr_bank][waddr] <= sc;
      end
    end
  end

endmodule

// File: tb/tb_fft4_input_reorder.sv
// Bench for fft4_input_reorder: frame-level model plus
// directed frames; PRESCALE=1 and PRESCALE=0 instances.
module tb_fft4_input_reorder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft4_input_reorder_if #(.WIDTH(32)) io1 ();
  fft4_input_reorder_if #(.WIDTH(32)) io0 ();

  fft4_input_reorder #(.WIDTH(32), .PRESCALE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .io(io1.slave)
  );
  fft4_input_reorder #(.WIDTH(32), .PRESCALE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .io(io0.slave)
  );

  assign io0.s_valid = io1.s_valid;
  assign io0.s_data  = io1.s_data;
  assign io0.s_last  = io1.s_last;
  assign io0.m_ready = io1.m_ready;

  int errors = 0;
  int checks = 0;

  task automatic chk(string n, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // model: queue of completed frames, slot order applied
  typedef struct packed {
    logic [3:0][31:0] s;
    logic [3:0][31:0] r;
  } frm_t;

  frm_t q[$];
  logic [3:0][31:0] cs;
  logic [3:0][31:0] cr;
  int   cn = 0;
  logic exp_err = 1'b0;

  function automatic logic [15:0] ps(input logic [15:0] c);
    int v;
    v = $signed(c);
    v = (v + 1) >>> 1;
    return v[15:0];
  endfunction

  always @(posedge clk) begin
    bit acc, rd;
    frm_t f;
    if (!rst_n) begin
      q.delete();
      cn = 0;
      exp_err = 1'b0;
    end else begin
      acc = io1.s_valid && (q.size() < 2);
      rd  = (q.size() > 0) && io1.m_ready;
      exp_err = 1'b0;
      if (rd) void'(q.pop_front());
      if (acc) begin
        cs[cn] = {ps(io1.s_data[31:16]), ps(io1.s_data[15:0])};
        cr[cn] = io1.s_data;
        cn++;
        if (cn == 4 && io1.s_last) begin
          f.s[0] = cs[0]; f.s[1] = cs[2];
          f.s[2] = cs[1]; f.s[3] = cs[3];
          f.r[0] = cr[0]; f.r[1] = cr[2];
          f.r[2] = cr[1]; f.r[3] = cr[3];
          q.push_back(f);
          cn = 0;
        end else if (cn == 4 || io1.s_last) begin
          exp_err = 1'b1;
          cn = 0;
        end
      end
    end
  end

  bit chk_en = 1'b0;
  bit win = 1'b0;
  int nv = 0;
  int ns = 0;
  int ne = 0;

  always @(negedge clk) begin
    logic [3:0][31:0] d1, d0;
    if (chk_en) begin
      chk("s_ready", io1.s_ready, q.size() < 2);
      chk("m_valid", io1.m_valid, q.size() > 0);
      chk("frame_err", io1.frame_err, exp_err);
      chk("m_valid_p0", io0.m_valid, q.size() > 0);
      d1 = {io1.m_x3, io1.m_x2, io1.m_x1, io1.m_x0};
      d0 = {io0.m_x3, io0.m_x2, io0.m_x1, io0.m_x0};
      if (q.size() > 0) begin
        for (int j = 0; j < 4; j++) begin
          chk($sformatf("slot%0d", j), d1[j], q[0].s[j]);
          chk($sformatf("p0_slot%0d", j), d0[j], q[0].r[j]);
        end
      end
      if (win) begin
        if (io1.m_valid) nv++;
        if (!io1.s_ready) ns++;
        if (io1.frame_err) ne++;
      end
    end
  end

  // call at a negedge; returns at the negedge after accept
  task automatic send(logic [31:0] d, logic l);
    int n;
    io1.s_valid = 1'b1;
    io1.s_data  = d;
    io1.s_last  = l;
    n = 0;
    while (!io1.s_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got stall expected accept");
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic idle(int n);
    io1.s_valid = 1'b0;
    io1.s_last  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(logic [31:0] a, logic [31:0] b,
                       logic [31:0] c, logic [31:0] d);
    send(a, 1'b0);
    send(b, 1'b0);
    send(c, 1'b0);
    send(d, 1'b1);
    io1.s_valid = 1'b0;
    io1.s_last  = 1'b0;
  endtask

  initial begin
    io1.s_valid = 1'b0;
    io1.s_data  = '0;
    io1.s_last  = 1'b0;
    io1.m_ready = 1'b0;
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_x0", io1.m_x0, 32'h0);
    chk("rst_x3", io1.m_x3, 32'h0);
    chk("rst_ready", io1.s_ready, 1'b1);
    chk("rst_valid", io1.m_valid, 1'b0);
    chk("rst_err", io1.frame_err, 1'b0);

    // basic frame
    io1.m_ready = 1'b1;
    frame(32'h20000000, 32'h00002000,
          32'hE0000000, 32'h0000E000);
    chk("basic_valid", io1.m_valid, 1'b1);
    chk("basic_x0", io1.m_x0, 32'h10000000);
    chk("basic_x1", io1.m_x1, 32'hF0000000);
    chk("basic_x2", io1.m_x2, 32'h00001000);
    chk("basic_x3", io1.m_x3, 32'h0000F000);
    chk("pass_x1", io0.m_x1, 32'hE0000000);
    chk("pass_x2", io0.m_x2, 32'h00002000);
    idle(2);

    // rounding, held under backpressure
    io1.m_ready = 1'b0;
    frame(32'h0003FFFD, 32'h00050007,
          32'h80007FFF, 32'hFFFF0001);
    idle(3);
    chk("rnd_x0", io1.m_x0, 32'h0002FFFF);
    chk("rnd_x1", io1.m_x1, 32'hC0004000);
    chk("rnd_x2", io1.m_x2, 32'h00030004);
    chk("rnd_x3", io1.m_x3, 32'h00000001);
    chk("rnd_p0", io0.m_x0, 32'h0003FFFD);
    io1.m_ready = 1'b1;
    idle(2);

    // backpressure: 12 samples, one-cycle read pulse
    io1.m_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          send({16'((i + 1) << 8), 16'(i << 4)}, (i % 4) == 3);
        end
        io1.s_valid = 1'b0;
        io1.s_last  = 1'b0;
      end
      begin
        repeat (12) @(negedge clk);
        chk("bp_stall", io1.s_ready, 1'b0);
        chk("bp_x0", io1.m_x0, 32'h00800000);
        io1.m_ready = 1'b1;
        @(negedge clk);
        io1.m_ready = 1'b0;
      end
    join
    idle(2);
    io1.m_ready = 1'b1;
    idle(4);

    // back-to-back throughput
    nv = 0; ns = 0; win = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send(32'h00010001 * (i + 3), (i % 4) == 3);
    end
    idle(2);
    win = 1'b0;
    chk("thru_frames", nv, 4);
    chk("thru_stalls", ns, 0);

    // short frame then good frame
    nv = 0; ne = 0; win = 1'b1;
    send(32'h11112222, 1'b0);
    send(32'h33334444, 1'b1);
    frame(32'h01000200, 32'h03000400,
          32'h05000600, 32'h07000800);
    idle(3);
    win = 1'b0;
    chk("short_err", ne, 1);
    chk("short_frames", nv, 1);

    // long frame: 4th sample without last
    nv = 0; ne = 0; win = 1'b1;
    for (int i = 0; i < 4; i++) send(32'h0A0A0B0B, 1'b0);
    idle(3);
    win = 1'b0;
    chk("long_err", ne, 1);
    chk("long_frames", nv, 0);

    // reset with a full bank and a partial frame
    io1.m_ready = 1'b0;
    frame(32'h40004000, 32'h40004000,
          32'h40004000, 32'h40004000);
    send(32'h12341234, 1'b0);
    send(32'h56785678, 1'b0);
    io1.s_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rstm_valid", io1.m_valid, 1'b0);
    chk("rstm_ready", io1.s_ready, 1'b1);
    io1.m_ready = 1'b1;
    frame(32'h00020000, 32'h00040000,
          32'h00060000, 32'h00080000);
    chk("rstm_x1", io1.m_x1, 32'h00030000);
    chk("rstm_x2", io1.m_x2, 32'h00020000);
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
